// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 miss-path arbiter: FSM state encoding and grant identity.
package rv32i_types;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE_I,
        S_SERVE_D_RD,
        S_SERVE_D_WR,
        S_RESP_I,
        S_RESP_D
    } arb_state_t;

    typedef enum logic {
        ARB_I,
        ARB_D
    } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_arb_select.sv
// Combinational grant pick between I-cache and D-cache miss requests.
module arb_select
    import rv32i_types::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       i_i_req,
    input  logic       i_d_req,
    input  arb_grant_t i_last_grant,
    output logic       o_valid,
    output arb_grant_t o_grant
);

    always_comb begin
        o_valid = i_i_req | i_d_req;
        o_grant = ARB_D;
        if (i_i_req && !i_d_req) begin
            o_grant = ARB_I;
        end else if (i_i_req && i_d_req && (RR_EN != 0) && (i_last_grant == ARB_D)) begin
            // Contention: alternate away from the side served last.
            o_grant = ARB_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem line port between I-cache and D-cache misses, one transaction at a time.
// state        | meaning
// S_IDLE       | sample requests, grant and latch address/wdata
// S_SERVE_I    | pmem read for I-cache, wait pmem_resp
// S_SERVE_D_RD | pmem read for D-cache, wait pmem_resp
// S_SERVE_D_WR | pmem writeback for D-cache, wait pmem_resp
// S_RESP_I     | one-cycle i_resp, no pmem strobe
// S_RESP_D     | one-cycle d_resp, no pmem strobe
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy
);

    arb_state_t        r_state;
    arb_grant_t        r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_line;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic              r_i_resp;
    logic              r_d_resp;
    logic              r_busy;

    logic              w_valid;
    arb_grant_t        w_grant;

    arb_select #(
        .RR_EN(RR_EN)
    ) u_arb_select (
        .i_i_req     (i_read),
        .i_d_req     (d_read | d_write),
        .i_last_grant(r_last_grant),
        .o_valid     (w_valid),
        .o_grant     (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= ARB_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_line       <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_last_grant <= w_grant;
                        r_busy       <= 1'b1;
                        if (w_grant == ARB_I) begin
                            r_state     <= S_SERVE_I;
                            r_addr      <= i_address;
                            r_pmem_read <= 1'b1;
                        end else if (d_write) begin
                            // Writeback wins over a concurrent D read; the read re-arbitrates later.
                            r_state      <= S_SERVE_D_WR;
                            r_addr       <= d_address;
                            r_wdata      <= d_wdata;
                            r_pmem_write <= 1'b1;
                        end else begin
                            r_state     <= S_SERVE_D_RD;
                            r_addr      <= d_address;
                            r_pmem_read <= 1'b1;
                        end
                    end
                end
                S_SERVE_I, S_SERVE_D_RD: begin
                    if (pmem_resp) begin
                        r_line      <= pmem_rdata;
                        r_pmem_read <= 1'b0;
                        if (r_state == S_SERVE_I) begin
                            r_state  <= S_RESP_I;
                            r_i_resp <= 1'b1;
                        end else begin
                            r_state  <= S_RESP_D;
                            r_d_resp <= 1'b1;
                        end
                    end
                end
                S_SERVE_D_WR: begin
                    if (pmem_resp) begin
                        r_pmem_write <= 1'b0;
                        r_state      <= S_RESP_D;
                        r_d_resp     <= 1'b1;
                    end
                end
                S_RESP_I, S_RESP_D: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign i_rdata      = r_line;
    assign d_rdata      = r_line;
    assign i_resp       = r_i_resp;
    assign d_resp       = r_d_resp;
    assign busy         = r_busy;

endmodule
